// File: rtl/caravel_clock_div_bank.sv
// Bank of NCH independent programmable clock dividers running from pll_clk.
// Each channel changes its divisor only at a period boundary, stops cleanly, and emits a tick on every rising edge of clk_out.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | channel stopped, clk_out low, waiting for en
//   RUN   | dividing by act; div/en sampled only when cnt wraps to zero
module caravel_clock_div_bank #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8
) (
    input  logic                 pll_clk,
    input  logic                 resetb,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] div,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       running,
    output logic [NCH-1:0]       pending
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Divisors 0 and 1 are clamped to 2 so that every output stays registered.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] act_q, act_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [WIDTH-1:0] div_c;
        logic [WIDTH-1:0] eff_c;
        logic [WIDTH-1:0] high_c;
        logic [WIDTH-1:0] cnt_inc;
        logic             wrap_c;

        assign div_c   = div[c*WIDTH +: WIDTH];
        assign eff_c   = eff_div(div_c);
        assign high_c  = act_q - (act_q >> 1);
        assign cnt_inc = cnt_q + WIDTH'(1);
        assign wrap_c  = (cnt_q == act_q - WIDTH'(1));

        always_ff @(posedge pll_clk or negedge resetb) begin
            if (!resetb) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                act_q   <= WIDTH'(2);
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                act_q   <= act_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            act_d   = act_q;
            clk_d   = clk_q;
            tick_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (en[c]) begin
                        state_d = RUN;
                        act_d   = eff_c;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (!wrap_c) begin
                        cnt_d = cnt_inc;
                        clk_d = (cnt_inc < high_c);
                    end else if (!en[c]) begin
                        // A stop request always beats a divisor change at the wrap.
                        state_d = IDLE;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                    end else begin
                        act_d  = eff_c;
                        cnt_d  = '0;
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end
            endcase
        end

        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
        assign running[c] = (state_q == RUN);
        assign pending[c] = (state_q == RUN) && (eff_c != act_q);
    end

endmodule

// File: tb/tb_caravel_clock_div_bank.sv
// Directed testbench for caravel_clock_div_bank (NCH=2, WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there as well.
module tb_caravel_clock_div_bank;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;

    logic                 pll_clk;
    logic                 resetb;
    logic [NCH-1:0]       en;
    logic [NCH*WIDTH-1:0] div;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       running;
    logic [NCH-1:0]       pending;

    int checks   = 0;
    int failures = 0;

    caravel_clock_div_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .pll_clk (pll_clk),
        .resetb  (resetb),
        .en      (en),
        .div     (div),
        .clk_out (clk_out),
        .tick    (tick),
        .running (running),
        .pending (pending)
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    task automatic edge_step();
        @(posedge pll_clk);
        #1;
    endtask

    // Pulses reset between rising edges so the next edge is a clean IDLE evaluation.
    task automatic restart();
        en     = '0;
        resetb = 1'b0;
        #2;
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        en     = '0;
        div    = '0;
        #2;
        checks++;
        if ({clk_out, tick, running, pending} !== '0) begin
            failures++;
            $display("FAIL reset_initial got=%b want=0", {clk_out, tick, running, pending});
        end
        edge_step();
        resetb = 1'b1;
        div[7:0] = 8'd5;
        en[0]    = 1'b1;
        edge_step();                       // cnt=0
        repeat (3) edge_step();            // cnt=3, high time 3 so clk_out low
        checks++;
        if (running[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_prerun running=%b clk=%b want running=1 clk=0", running[0], clk_out[0]);
        end
        edge_step();                       // cnt=4
        #2;
        resetb = 1'b0;
        #1;
        checks++;
        if ({clk_out, tick, running, pending} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%b want=0", {clk_out, tick, running, pending});
        end
        edge_step();
        en     = '0;
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            checks++;
            if ({clk_out, tick, running, pending} !== '0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b want=0", i, {clk_out, tick, running, pending});
            end
        end
    endtask

    task automatic test_even_odd();
        logic [3:0] pat4;
        logic [2:0] pat3;
        pat4 = 4'b1100;
        pat3 = 3'b110;
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 4 : 3;
            restart();
            div[7:0] = 8'(d);
            en[0]    = 1'b1;
            for (int i = 0; i < 3 * d; i++) begin
                logic exp_clk;
                edge_step();
                exp_clk = (d == 4) ? pat4[3 - (i % 4)] : pat3[2 - (i % 3)];
                checks++;
                if (clk_out[0] !== exp_clk || tick[0] !== ((i % d) == 0) || running[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL div%0d cyc=%0d clk=%b tick=%b run=%b want clk=%b tick=%b run=1",
                             d, i, clk_out[0], tick[0], running[0], exp_clk, ((i % d) == 0));
                end
            end
        end
    endtask

    task automatic test_glitch_free();
        logic [3:0] exp_clk4;
        logic [2:0] pat3;
        exp_clk4 = 4'b1000;                // cnt 2..5 of a divide-by-6 period
        pat3     = 3'b110;
        restart();
        div[7:0] = 8'd6;
        en[0]    = 1'b1;
        edge_step();                       // cnt=0
        edge_step();                       // cnt=1
        div[7:0] = 8'd3;
        #1;
        checks++;
        if (pending[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL change_pending_now pend=%b clk=%b want pend=1 clk=1", pending[0], clk_out[0]);
        end
        for (int i = 0; i < 4; i++) begin
            edge_step();
            checks++;
            if (pending[0] !== 1'b1 || clk_out[0] !== exp_clk4[3 - i] || tick[0] !== 1'b0) begin
                failures++;
                $display("FAIL change_old_period cyc=%0d pend=%b clk=%b tick=%b want pend=1 clk=%b tick=0",
                         i, pending[0], clk_out[0], tick[0], exp_clk4[3 - i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            edge_step();
            checks++;
            if (pending[0] !== 1'b0 || clk_out[0] !== pat3[2 - (i % 3)] || tick[0] !== ((i % 3) == 0)) begin
                failures++;
                $display("FAIL change_new_period cyc=%0d pend=%b clk=%b tick=%b want pend=0 clk=%b tick=%b",
                         i, pending[0], clk_out[0], tick[0], pat3[2 - (i % 3)], ((i % 3) == 0));
            end
        end
    endtask

    task automatic test_stop();
        logic [4:0] exp_clk5;
        exp_clk5 = 5'b10000;               // cnt 3..7 of a divide-by-8 period
        restart();
        div[7:0] = 8'd8;
        en[0]    = 1'b1;
        edge_step();                       // cnt=0
        edge_step();                       // cnt=1
        edge_step();                       // cnt=2
        en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            checks++;
            if (running[0] !== 1'b1 || clk_out[0] !== exp_clk5[4 - i] || tick[0] !== 1'b0) begin
                failures++;
                $display("FAIL stop_finish cyc=%0d run=%b clk=%b tick=%b want run=1 clk=%b tick=0",
                         i, running[0], clk_out[0], tick[0], exp_clk5[4 - i]);
            end
        end
        div[7:0] = 8'd3;                   // change at the wrap must be ignored by the stop
        for (int i = 0; i < 6; i++) begin
            edge_step();
            checks++;
            if (running[0] !== 1'b0 || clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || pending[0] !== 1'b0) begin
                failures++;
                $display("FAIL stop_idle cyc=%0d run=%b clk=%b tick=%b pend=%b want all 0",
                         i, running[0], clk_out[0], tick[0], pending[0]);
            end
        end
    endtask

    task automatic test_cancel_stop();
        restart();
        div[7:0] = 8'd4;
        en[0]    = 1'b1;
        edge_step();                       // cnt=0
        edge_step();                       // cnt=1
        en[0] = 1'b0;
        edge_step();                       // cnt=2
        en[0] = 1'b1;
        edge_step();                       // cnt=3
        edge_step();                       // wrap
        checks++;
        if (running[0] !== 1'b1 || clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL cancel_stop run=%b clk=%b tick=%b want 1 1 1", running[0], clk_out[0], tick[0]);
        end
    endtask

    task automatic test_clamp();
        restart();
        div[7:0] = 8'd0;
        en[0]    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            checks++;
            if (clk_out[0] !== ((i % 2) == 0) || tick[0] !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL clamp_div0 cyc=%0d clk=%b tick=%b want %b", i, clk_out[0], tick[0], ((i % 2) == 0));
            end
        end
        div[7:0] = 8'd1;
        #1;
        checks++;
        if (pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL clamp_pending got=%b want=0", pending[0]);
        end
        restart();
        div[7:0] = 8'd1;
        en[0]    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            checks++;
            if (clk_out[0] !== ((i % 2) == 0) || tick[0] !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL clamp_div1 cyc=%0d clk=%b tick=%b want %b", i, clk_out[0], tick[0], ((i % 2) == 0));
            end
        end
    endtask

    task automatic test_independence();
        logic [4:0] pat5;
        pat5 = 5'b11100;
        restart();
        div = {8'd5, 8'd2};
        en  = 2'b11;
        for (int i = 0; i < 20; i++) begin
            logic [1:0] exp_clk;
            logic [1:0] exp_tick;
            edge_step();
            exp_clk  = {pat5[4 - (i % 5)], ((i % 2) == 0)};
            exp_tick = {((i % 5) == 0), ((i % 2) == 0)};
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick || running !== 2'b11) begin
                failures++;
                $display("FAIL indep cyc=%0d clk=%b tick=%b run=%b want clk=%b tick=%b run=11",
                         i, clk_out, tick, running, exp_clk, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_odd();
        test_glitch_free();
        test_stop();
        test_cancel_stop();
        test_clamp();
        test_independence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
